// File: rtl/uart_word_loader.sv
// uart_word_loader: UART boot loader that assembles framed bytes into 32-bit memory writes
// and returns a one-byte ack ('K' loaded, 'E' error) on TX.
module uart_word_loader #(
    parameter int CLK_HZ    = 10_000_000,
    parameter int BAUD      = 115200,
    parameter int MAX_WORDS = 16384
) (
    input  logic        upg_clk_i,
    input  logic        upg_rst_i,
    input  logic        upg_rx_i,
    output logic        upg_clk_o,
    output logic        upg_wen_o,
    output logic [14:0] upg_adr_o,
    output logic [31:0] upg_dat_o,
    output logic        upg_done_o,
    output logic        upg_tx_o
);
    localparam int DIV = CLK_HZ / BAUD;
    localparam int CW = $clog2(DIV) + 1;
    localparam logic [CW-1:0] FULL = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF = CW'(DIV / 2 - 1);

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_st_t;
    typedef enum logic [1:0] {T_IDLE, T_START, T_DATA, T_STOP} tx_st_t;
    typedef enum logic [2:0] {F_HDR0, F_HDR1, F_HDR2, F_DATA, F_DONE} fr_st_t;

    rx_st_t r_st, r_nxt;
    tx_st_t t_st, t_nxt;
    fr_st_t f_st, f_nxt;
    logic rx_s1, rx_s2, rx_q, r_tick, byte_valid, ferr;
    logic [CW-1:0] r_cnt, t_cnt;
    logic [2:0] r_bit, t_bit;
    logic [7:0] r_sh, t_sh;
    logic t_tick, tx_req, go_done, go_err, wr, target;
    logic [15:0] n_words, n_hdr;
    logic [14:0] idx, idx_inc;
    logic [1:0] bsel;
    logic [31:0] wbuf;

    assign upg_clk_o = upg_clk_i;
    assign tx_req = go_done | go_err;

    // Start is an edge, not a level, so a low line left over from a bad stop bit is not a new byte.
    always_comb begin
        r_tick = r_cnt == (r_st == R_START ? HALF : FULL);
        r_nxt = r_st;
        byte_valid = 1'b0;
        ferr = 1'b0;
        case (r_st)
            R_IDLE:  r_nxt = (rx_q && !rx_s2) ? R_START : R_IDLE;
            R_START: r_nxt = r_tick ? (rx_s2 ? R_IDLE : R_DATA) : R_START;
            R_DATA:  r_nxt = (r_tick && r_bit == 3'd7) ? R_STOP : R_DATA;
            default: begin
                r_nxt = r_tick ? R_IDLE : R_STOP;
                byte_valid = r_tick && rx_s2;
                ferr = r_tick && !rx_s2;
            end
        endcase
    end

    always_ff @(posedge upg_clk_i or negedge upg_rst_i) begin
        if (!upg_rst_i) begin
            {rx_s1, rx_s2, rx_q} <= 3'b111;
            r_st <= R_IDLE;
            r_cnt <= '0;
            r_bit <= '0;
            r_sh <= '0;
        end else begin
            rx_s1 <= upg_rx_i;
            rx_s2 <= rx_s1;
            rx_q <= rx_s2;
            r_st <= r_nxt;
            r_cnt <= (r_st == R_IDLE || r_tick) ? '0 : r_cnt + 1'b1;
            if (r_st == R_DATA && r_tick) begin
                r_sh <= {rx_s2, r_sh[7:1]};
                r_bit <= r_bit + 3'd1;
            end
        end
    end

    always_comb begin
        n_hdr = {r_sh, n_words[7:0]};
        idx_inc = idx + 15'd1;
        f_nxt = f_st;
        go_done = 1'b0;
        go_err = 1'b0;
        wr = 1'b0;
        if (ferr && f_st != F_DONE) begin
            f_nxt = F_HDR0;
            go_err = 1'b1;
        end else if (byte_valid) begin
            case (f_st)
                F_HDR0: f_nxt = F_HDR1;
                F_HDR1: f_nxt = F_HDR2;
                F_HDR2: begin
                    go_done = n_hdr == 16'd0;
                    go_err = {1'b0, n_hdr} > 17'(MAX_WORDS);
                    f_nxt = go_done ? F_DONE : go_err ? F_HDR0 : F_DATA;
                end
                F_DATA: begin
                    wr = bsel == 2'd3;
                    go_done = wr && {1'b0, idx_inc} == n_words;
                    f_nxt = go_done ? F_DONE : F_DATA;
                end
                default: f_nxt = f_st;
            endcase
        end
    end

    always_ff @(posedge upg_clk_i or negedge upg_rst_i) begin
        if (!upg_rst_i) begin
            f_st <= F_HDR0;
            target <= 1'b0;
            n_words <= '0;
            idx <= '0;
            bsel <= '0;
            wbuf <= '0;
            upg_wen_o <= 1'b0;
            upg_adr_o <= '0;
            upg_dat_o <= '0;
            upg_done_o <= 1'b0;
        end else begin
            f_st <= f_nxt;
            upg_wen_o <= wr;
            upg_done_o <= upg_done_o | (f_st == F_DONE);
            if (go_err) begin
                idx <= '0;
                bsel <= '0;
            end else if (byte_valid) begin
                case (f_st)
                    F_HDR0: target <= r_sh[0];
                    F_HDR1: n_words[7:0] <= r_sh;
                    F_HDR2: begin
                        n_words[15:8] <= r_sh;
                        idx <= '0;
                        bsel <= '0;
                    end
                    F_DATA: begin
                        wbuf <= {r_sh, wbuf[31:8]};
                        bsel <= bsel + 2'd1;
                        if (wr) begin
                            upg_dat_o <= {r_sh, wbuf[31:8]};
                            upg_adr_o <= {target, idx[13:0]};
                            idx <= idx_inc;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Acks arriving while a byte is still going out are dropped, never queued.
    always_comb begin
        t_tick = t_cnt == FULL;
        t_nxt = t_st;
        case (t_st)
            T_IDLE:  t_nxt = tx_req ? T_START : T_IDLE;
            T_START: t_nxt = t_tick ? T_DATA : T_START;
            T_DATA:  t_nxt = (t_tick && t_bit == 3'd7) ? T_STOP : T_DATA;
            default: t_nxt = t_tick ? T_IDLE : T_STOP;
        endcase
    end

    always_ff @(posedge upg_clk_i or negedge upg_rst_i) begin
        if (!upg_rst_i) begin
            t_st <= T_IDLE;
            t_cnt <= '0;
            t_bit <= '0;
            t_sh <= '0;
            upg_tx_o <= 1'b1;
        end else begin
            t_st <= t_nxt;
            t_cnt <= (t_st == T_IDLE || t_tick) ? '0 : t_cnt + 1'b1;
            if (t_st == T_IDLE && tx_req) begin
                t_sh <= go_err ? 8'h45 : 8'h4B;
                upg_tx_o <= 1'b0;
            end else if (t_tick) begin
                case (t_st)
                    T_START: upg_tx_o <= t_sh[0];
                    T_DATA: begin
                        t_sh <= t_sh >> 1;
                        t_bit <= t_bit + 3'd1;
                        upg_tx_o <= t_bit == 3'd7 ? 1'b1 : t_sh[1];
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule
